fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 126 ++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a START/RUN/HALT sequencer.
// Optional misaligned-redirect trap is enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
    parameter logic [9:0]  RESET_PC  = 10'h000,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [9:0]  redirect_pc,
    output logic [9:0]  imem_pc,
    input  logic [31:0] imem_instr,
    output logic [9:0]  ifid_pc,
    output logic [31:0] ifid_instr,
    output logic        ifid_valid,
    output logic        fetch_fault,
    output logic [1:0]  state_dbg
);

    // Handshake: there is no backpressure handshake; ifid_valid qualifies ifid_pc/ifid_instr
    // every cycle, and stall freezes the whole stage (the consumer sees the same word again).

    typedef enum logic [1:0] {
        START = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [9:0]  pc, pc_n;
    logic [9:0]  ifid_pc_n;
    logic [31:0] ifid_instr_n;
    logic        ifid_valid_n;
    logic        fault, fault_n;
    logic        misaligned;
    logic [9:0]  redirect_target;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign redirect_target = redirect_pc;
    assign misaligned      = (redirect_pc[1:0] != 2'b00);
`else
    // Without the trap the low bits are simply dropped (target aligned down).
    assign redirect_target = redirect_pc & 10'h3FC;
    assign misaligned      = 1'b0;
`endif

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        ifid_pc_n    = ifid_pc;
        ifid_instr_n = ifid_instr;
        ifid_valid_n = ifid_valid;
        fault_n      = fault;
        case (state)
            START: begin
                // One bubble edge after reset; stall and redirect are ignored here.
                state_n = RUN;
            end
            RUN: begin
                if (redirect) begin
                    ifid_pc_n    = 10'h000;
                    ifid_instr_n = NOP_INSTR;
                    ifid_valid_n = 1'b0;
                    if (misaligned) begin
                        fault_n = 1'b1;
                        state_n = HALT;
                    end else begin
                        pc_n = redirect_target;
                    end
                end else if (!stall) begin
                    pc_n         = pc + 10'd4;
                    ifid_pc_n    = pc;
                    ifid_instr_n = imem_instr;
                    ifid_valid_n = 1'b1;
                end
            end
            HALT: begin
                ifid_instr_n = NOP_INSTR;
                ifid_valid_n = 1'b0;
            end
            default: begin
                state_n = START;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= START;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc         <= RESET_PC;
            ifid_pc    <= 10'h000;
            ifid_instr <= NOP_INSTR;
            ifid_valid <= 1'b0;
        end else begin
            pc         <= pc_n;
            ifid_pc    <= ifid_pc_n;
            ifid_instr <= ifid_instr_n;
            ifid_valid <= ifid_valid_n;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault <= 1'b0;
        end else begin
            fault <= fault_n;
        end
    end
`else
    assign fault = 1'b0;
`endif

    assign imem_pc     = pc;
    assign fetch_fault = fault;
    assign state_dbg   = state;

endmodule
